// File: rtl/pcode_correlator_pkg.sv
// Shared types and defaults for the P-code correlator.
// No logic; compile-time constants only.
// Not applicable (no datapath).
package pcode_correlator_pkg;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int LOCK_CNT_DEF  = 3;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/pcode_corr_acc.sv
// Single correlator tap: +/-1 accumulate per chip, dump register loaded on the last chip.
// Latency: dump_dat valid one clock after the edge sampling the last chip; sum is combinational.
// No backpressure; the parent decides when to dump, and a dump always overwrites.
module pcode_corr_acc #(
    parameter int ACC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        restart,
    input  logic                        en,
    input  logic                        chip,
    input  logic                        tap,
    input  logic                        dump_ld,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [ACC_WIDTH-1:0] dump_dat
);

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] step;

    // Agreement contributes +1, disagreement -1 (all ones).
    assign step = (chip == tap) ? {{(ACC_WIDTH-1){1'b0}}, 1'b1} : {ACC_WIDTH{1'b1}};
    assign sum  = acc_q + step;

    // Accumulate on each strobe; on the dump chip move the sum out and restart from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            dump_dat <= '0;
        end else if (restart) begin
            acc_q    <= '0;
            dump_dat <= '0;
        end else if (en) begin
            if (dump_ld) begin
                acc_q    <= '0;
                dump_dat <= sum;
            end else begin
                acc_q    <= sum;
            end
        end
    end

endmodule

// File: rtl/pcode_correlator.sv
// Early/prompt/late despreader with programmable integration, dump handshake and lock detector.
// Latency: dump and locked visible one clock after the edge that sampled the last chip.
// Dumps never stall: an unconsumed dump is overwritten and the sticky overrun flag is set.
module pcode_correlator
    import pcode_correlator_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int LOCK_CNT  = LOCK_CNT_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        restart,
    input  logic                        en,
    input  logic                        chip_in,
    input  logic                        code_in,
    input  logic [ACC_WIDTH-2:0]        int_len,
    input  logic [ACC_WIDTH-2:0]        lock_thresh,
    output logic signed [ACC_WIDTH-1:0] early,
    output logic signed [ACC_WIDTH-1:0] prompt,
    output logic signed [ACC_WIDTH-1:0] late,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic                        overrun,
    output logic                        locked
);

    localparam int CW = $clog2(LOCK_CNT + 1);

    logic                        code_d1, code_d2;
    logic [ACC_WIDTH-2:0]        chip_cnt;
    logic [ACC_WIDTH-2:0]        eff_len;
    logic                        last_chip;
    logic                        dump_ld;
    logic signed [ACC_WIDTH-1:0] early_sum, prompt_sum, late_sum;
    logic [ACC_WIDTH-1:0]        prompt_mag;
    logic                        hit;
    lock_state_t                 state_q, state_nxt;
    logic [CW-1:0]               hit_cnt_q, hit_cnt_nxt, cnt_inc;

    // A zero length would never terminate, so it behaves as a one-chip integration.
    assign eff_len   = (int_len == '0) ? {{(ACC_WIDTH-2){1'b0}}, 1'b1} : int_len;
    assign last_chip = (chip_cnt == eff_len - 1'b1);
    assign dump_ld   = en & last_chip & ~restart;

    // Replica delay line giving the prompt (1 strobe) and late (2 strobes) taps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_d1 <= 1'b0;
            code_d2 <= 1'b0;
        end else if (restart) begin
            code_d1 <= 1'b0;
            code_d2 <= 1'b0;
        end else if (en) begin
            code_d1 <= code_in;
            code_d2 <= code_d1;
        end
    end

    // Chip counter within the current integration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chip_cnt <= '0;
        end else if (restart) begin
            chip_cnt <= '0;
        end else if (en) begin
            chip_cnt <= last_chip ? '0 : chip_cnt + 1'b1;
        end
    end

    pcode_corr_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc_early (
        .clk(clk), .reset_n(reset_n), .restart(restart), .en(en), .chip(chip_in),
        .tap(code_in), .dump_ld(dump_ld), .sum(early_sum), .dump_dat(early)
    );

    pcode_corr_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc_prompt (
        .clk(clk), .reset_n(reset_n), .restart(restart), .en(en), .chip(chip_in),
        .tap(code_d1), .dump_ld(dump_ld), .sum(prompt_sum), .dump_dat(prompt)
    );

    pcode_corr_acc #(.ACC_WIDTH(ACC_WIDTH)) u_acc_late (
        .clk(clk), .reset_n(reset_n), .restart(restart), .en(en), .chip(chip_in),
        .tap(code_d2), .dump_ld(dump_ld), .sum(late_sum), .dump_dat(late)
    );

    // Magnitude fits unsigned ACC_WIDTH bits even for the most negative value.
    assign prompt_mag = prompt_sum[ACC_WIDTH-1] ? $unsigned(-prompt_sum) : $unsigned(prompt_sum);
    assign hit        = (prompt_mag >= {1'b0, lock_thresh});

    // Dump handshake: new dump wins over consumption; overwrite of unread data is sticky.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dump_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (restart) begin
            dump_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (dump_ld) begin
            dump_valid <= 1'b1;
            if (dump_valid && !dump_ready) begin
                overrun <= 1'b1;
            end
        end else if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
        end
    end

    // Lock state register; locked is registered alongside so it updates with the dump.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEARCH;
            hit_cnt_q <= '0;
            locked    <= 1'b0;
        end else if (restart) begin
            state_q   <= SEARCH;
            hit_cnt_q <= '0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            hit_cnt_q <= hit_cnt_nxt;
            locked    <= (state_nxt == LOCKED);
        end
    end

    assign cnt_inc = hit_cnt_q + 1'b1;

    // Lock next-state: only advances on a dump; counts consecutive hits (or misses while locked).
    always_comb begin
        state_nxt   = state_q;
        hit_cnt_nxt = hit_cnt_q;
        if (dump_ld) begin
            case (state_q)
                SEARCH: begin
                    if (hit) begin
                        state_nxt   = VERIFY;
                        hit_cnt_nxt = {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                VERIFY: begin
                    if (!hit) begin
                        state_nxt   = SEARCH;
                        hit_cnt_nxt = '0;
                    end else if (cnt_inc == CW'(LOCK_CNT)) begin
                        state_nxt   = LOCKED;
                        hit_cnt_nxt = '0;
                    end else begin
                        hit_cnt_nxt = cnt_inc;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        hit_cnt_nxt = '0;
                    end else if (cnt_inc == CW'(LOCK_CNT)) begin
                        state_nxt   = SEARCH;
                        hit_cnt_nxt = '0;
                    end else begin
                        hit_cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt   = SEARCH;
                    hit_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcode_correlator.sv
// Directed bench for pcode_correlator: table of integrations plus handshake/restart/reset sequences.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Expected dump values are hand-computed for the 8-chip code 1,0,1,1,0,0,1,0.
module tb_pcode_correlator;

    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 restart;
    logic                 en;
    logic                 chip_in;
    logic                 code_in;
    logic [AW-2:0]        int_len;
    logic [AW-2:0]        lock_thresh;
    logic signed [AW-1:0] early, prompt, late;
    logic                 dump_valid;
    logic                 dump_ready;
    logic                 overrun;
    logic                 locked;

    int n_chk  = 0;
    int n_fail = 0;

    bit code_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int gen_idx = 0;
    bit prev    = 1'b0;

    // mode: 0 aligned (chip = code one strobe late), 1 inverted, 2 chip held at 1
    typedef struct {
        int mode;
        bit gap;
        int thresh;
        int e;
        int p;
        int l;
        bit lk;
    } row_t;

    row_t tbl [11];

    always #5 clk = ~clk;

    pcode_correlator #(.ACC_WIDTH(AW), .LOCK_CNT(3)) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .en(en),
        .chip_in(chip_in), .code_in(code_in), .int_len(int_len),
        .lock_thresh(lock_thresh), .early(early), .prompt(prompt), .late(late),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .overrun(overrun),
        .locked(locked)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_strobe(input int mode);
        @(negedge clk);
        code_in = code_pat[gen_idx];
        case (mode)
            1:       chip_in = ~prev;
            2:       chip_in = 1'b1;
            default: chip_in = prev;
        endcase
        prev    = code_pat[gen_idx];
        gen_idx = (gen_idx + 1) % 8;
        en      = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_strobes(input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            drive_strobe(mode);
            settle();
        end
    endtask

    task automatic do_restart(input bit keep_en);
        @(negedge clk);
        restart = 1'b1;
        en      = keep_en;
        settle();
        restart = 1'b0;
        en      = 1'b0;
        gen_idx = 0;
        prev    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_early"},  early,      0);
        chk({tag, "_prompt"}, prompt,     0);
        chk({tag, "_late"},   late,       0);
        chk({tag, "_valid"},  dump_valid, 0);
        chk({tag, "_ovr"},    overrun,    0);
        chk({tag, "_locked"}, locked,     0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 1'b0, 6, -4,  8, -2, 1'b0};
        tbl[1]  = '{0, 1'b1, 6, -4,  8, -4, 1'b0};
        tbl[2]  = '{0, 1'b0, 6, -4,  8, -4, 1'b1};
        tbl[3]  = '{2, 1'b0, 6,  0,  0,  0, 1'b1};
        tbl[4]  = '{0, 1'b0, 6, -4,  8, -4, 1'b1};
        tbl[5]  = '{2, 1'b0, 6,  0,  0,  0, 1'b1};
        tbl[6]  = '{2, 1'b0, 6,  0,  0,  0, 1'b1};
        tbl[7]  = '{2, 1'b0, 6,  0,  0,  0, 1'b0};
        tbl[8]  = '{1, 1'b0, 6,  4, -8,  4, 1'b0};
        tbl[9]  = '{1, 1'b0, 8,  4, -8,  4, 1'b0};
        tbl[10] = '{1, 1'b0, 6,  4, -8,  4, 1'b1};

        reset_n     = 1'b0;
        restart     = 1'b0;
        en          = 1'b0;
        chip_in     = 1'b0;
        code_in     = 1'b0;
        int_len     = 15'd8;
        lock_thresh = 15'd6;
        dump_ready  = 1'b1;

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Table of back-to-back integrations with ready held high.
        for (int r = 0; r < 11; r++) begin
            lock_thresh = tbl[r].thresh[AW-2:0];
            for (int i = 0; i < 8; i++) begin
                if (tbl[r].gap && i == 4) begin
                    idle();
                    settle();
                    chk($sformatf("row%0d_gap_valid", r), dump_valid, 0);
                end
                drive_strobe(tbl[r].mode);
                settle();
                if (i == 0) chk($sformatf("row%0d_valid_clr", r), dump_valid, 0);
                if (i == 6) chk($sformatf("row%0d_no_early_dump", r), dump_valid, 0);
                if (i == 7) begin
                    chk($sformatf("row%0d_valid", r),  dump_valid, 1);
                    chk($sformatf("row%0d_early", r),  early,      tbl[r].e);
                    chk($sformatf("row%0d_prompt", r), prompt,     tbl[r].p);
                    chk($sformatf("row%0d_late", r),   late,       tbl[r].l);
                    chk($sformatf("row%0d_ovr", r),    overrun,    0);
                    chk($sformatf("row%0d_locked", r), locked,     tbl[r].lk);
                end
            end
        end

        // Restart after 5 chips while locked; restart beats en on the same edge.
        lock_thresh = 15'd6;
        run_strobes(0, 5);
        do_restart(1'b1);
        chk_all_zero("restart");
        run_strobes(0, 7);
        chk("rst_no_dump_7", dump_valid, 0);
        run_strobes(0, 1);
        chk("rst_dump_8",    dump_valid, 1);
        chk("rst_prompt",    prompt,     8);
        chk("rst_early",     early,      -4);
        chk("rst_late",      late,       -2);
        chk("rst_locked",    locked,     0);

        // int_len = 0 behaves as a one-chip integration.
        do_restart(1'b0);
        int_len = 15'd0;
        run_strobes(0, 1);
        chk("len0_valid",  dump_valid, 1);
        chk("len0_prompt", prompt,     1);
        chk("len0_early",  early,      -1);
        chk("len0_late",   late,       1);
        int_len = 15'd8;

        // Overrun: two dumps with ready low.
        do_restart(1'b0);
        dump_ready = 1'b0;
        run_strobes(0, 8);
        chk("ovr_first_valid", dump_valid, 1);
        chk("ovr_first_flag",  overrun,    0);
        run_strobes(1, 8);
        chk("ovr_valid",  dump_valid, 1);
        chk("ovr_flag",   overrun,    1);
        chk("ovr_prompt", prompt,     -8);
        chk("ovr_early",  early,      4);
        chk("ovr_late",   late,       4);
        idle();
        dump_ready = 1'b1;
        settle();
        chk("ovr_consumed", dump_valid, 0);
        chk("ovr_sticky",   overrun,    1);
        chk("ovr_hold",     prompt,     -8);
        idle();
        settle();
        chk("ovr_sticky2",  overrun,    1);
        do_restart(1'b0);
        chk("ovr_restart",  overrun,    0);

        // New dump on the same edge the old one is consumed.
        dump_ready = 1'b0;
        run_strobes(0, 8);
        chk("coin_first_valid", dump_valid, 1);
        for (int i = 0; i < 8; i++) begin
            drive_strobe(1);
            dump_ready = (i == 7);
            settle();
            if (i == 3) chk("coin_held_valid", dump_valid, 1);
        end
        chk("coin_valid",  dump_valid, 1);
        chk("coin_ovr",    overrun,    0);
        chk("coin_prompt", prompt,     -8);
        idle();
        settle();
        chk("coin_consumed", dump_valid, 0);

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_prompt", prompt, 0);
        chk("areset_early",  early,  0);
        chk("areset_late",   late,   0);
        chk("areset_valid",  dump_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
